// File: rtl/sha_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core among NUM_REQ boot-flow requesters.
// A grant is held for a whole multi-block message; a watchdog revokes an idle owner.
module sha_core_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BLOCK_W  = 512,
  parameter int DIGEST_W = 256,
  parameter int TIMEOUT  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         init_i,
  input  logic [NUM_REQ-1:0]         next_i,
  input  logic [NUM_REQ*BLOCK_W-1:0] block_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [NUM_REQ-1:0]         ready_o,
  output logic [NUM_REQ-1:0]         digest_valid_o,
  output logic [DIGEST_W-1:0]        digest_o,
  output logic                       sha_init_o,
  output logic                       sha_next_o,
  output logic [BLOCK_W-1:0]         sha_block_o,
  input  logic                       sha_ready_i,
  input  logic                       sha_digest_valid_i,
  input  logic [DIGEST_W-1:0]        sha_digest_i,
  output logic                       proto_err_o,
  output logic                       timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OWNED,
    S_ISSUE,
    S_WAIT,
    S_BUSY,
    S_DRAIN
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [NUM_REQ-1:0] blocked, blocked_nxt;
  logic [WD_W-1:0]    wdog, wdog_nxt;
  logic [IDX_W:0]     pick;
  logic               sha_init_nxt, sha_next_nxt, block_load;
  logic               proto_err_nxt, timeout_nxt, revoke;
  logic               own_req, own_init, own_next, owned;
  logic [NUM_REQ-1:0] issue_any;

  // Returns {found, index} of the first eligible requester at or after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    logic [IDX_W:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_REQ)) idx = idx - (IDX_W+1)'(NUM_REQ);
      if (elig[idx[IDX_W-1:0]]) res = {1'b1, idx[IDX_W-1:0]};
    end
    return res;
  endfunction

  assign own_req   = req_i[owner];
  assign own_init  = init_i[owner];
  assign own_next  = next_i[owner];
  assign owned     = (state == S_OWNED);
  assign issue_any = init_i | next_i;

  // Core status reaches only the owner, and only while it may issue.
  assign ready_o        = owned ? (grant_o & {NUM_REQ{sha_ready_i}}) : '0;
  assign digest_valid_o = owned ? (grant_o & {NUM_REQ{sha_digest_valid_i}}) : '0;
  assign digest_o       = sha_digest_i;

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant_o;
    wdog_nxt     = wdog;
    sha_init_nxt = 1'b0;
    sha_next_nxt = 1'b0;
    block_load   = 1'b0;
    timeout_nxt  = 1'b0;
    revoke       = 1'b0;
    pick         = rr_pick(req_i & ~blocked, rr_ptr);

    unique case (state)
      S_IDLE: begin
        if (pick[IDX_W]) begin
          owner_nxt              = pick[IDX_W-1:0];
          grant_nxt              = '0;
          grant_nxt[pick[IDX_W-1:0]] = 1'b1;
          wdog_nxt               = '0;
          state_nxt              = S_OWNED;
        end
      end
      S_OWNED: begin
        if (!own_req) begin
          grant_nxt = '0;
          state_nxt = S_DRAIN;
        end else if (own_init || own_next) begin
          // init wins over a simultaneous next
          block_load   = 1'b1;
          sha_init_nxt = own_init;
          sha_next_nxt = !own_init;
          wdog_nxt     = '0;
          state_nxt    = S_ISSUE;
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
          revoke      = 1'b1;
          grant_nxt   = '0;
          state_nxt   = S_DRAIN;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_BUSY;
      S_BUSY: begin
        if (sha_ready_i) begin
          if (own_req) begin
            state_nxt = S_OWNED;
          end else begin
            grant_nxt = '0;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        rr_ptr_nxt = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        wdog_nxt   = '0;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A revoked requester stays ineligible until it lowers its request.
  always_comb begin
    blocked_nxt = (blocked | (revoke ? grant_o : '0)) & req_i;
    if (owned) proto_err_nxt = (|(issue_any & ~grant_o)) | (own_init & own_next);
    else       proto_err_nxt = |issue_any;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      grant_o     <= '0;
      blocked     <= '0;
      wdog        <= '0;
      sha_init_o  <= 1'b0;
      sha_next_o  <= 1'b0;
      sha_block_o <= '0;
      proto_err_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant_o     <= grant_nxt;
      blocked     <= blocked_nxt;
      wdog        <= wdog_nxt;
      sha_init_o  <= sha_init_nxt;
      sha_next_o  <= sha_next_nxt;
      proto_err_o <= proto_err_nxt;
      timeout_o   <= timeout_nxt;
      if (block_load) sha_block_o <= block_i[owner*BLOCK_W +: BLOCK_W];
    end
  end

endmodule
